// File: rtl/cr_prefix_attach_ob_buf_if.sv
// TLV bus type and buffer handshake interface for the prefix-attach output buffer.
// slave: buffer side (write in, FWFT read out); master: controller/downstream side.
package cr_prefix_pkg;
  typedef struct packed {
    logic        sot;
    logic        eot;
    logic [3:0]  typen;
    logic [31:0] tdata;
  } tlvp_if_bus_t;
endpackage

interface cr_prefix_attach_ob_buf_if;
  import cr_prefix_pkg::*;
  logic         usr_ob_wr;
  tlvp_if_bus_t usr_ob_tlv;
  logic         usr_ob_full;
  logic         usr_ob_afull;
  logic         ob_rd;
  logic         ob_empty;
  logic         ob_aempty;
  tlvp_if_bus_t ob_tlv;

  modport slave (
    input  usr_ob_wr, usr_ob_tlv, ob_rd,
    output usr_ob_full, usr_ob_afull,
    output ob_empty, ob_aempty, ob_tlv
  );

  modport master (
    output usr_ob_wr, usr_ob_tlv, ob_rd,
    input  usr_ob_full, usr_ob_afull,
    input  ob_empty, ob_aempty, ob_tlv
  );
endinterface

// File: rtl/cr_prefix_attach_ob_buf.sv
// FWFT output buffer after the prefix-attach controller with TLV framing checks.
// Ports: clk, rst_n (async low), bus (write/read handshake), err_clr, sticky
// ovf/unf/frame errors, stat_* counters (live only with CR_PREFIX_OB_STATS_EN).
module cr_prefix_attach_ob_buf
  import cr_prefix_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int AFULL_GAP  = 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic clk,
  input  logic rst_n,
  cr_prefix_attach_ob_buf_if.slave bus,
  input  logic err_clr,
  output logic ovf_err,
  output logic unf_err,
  output logic frame_err,
  output logic [31:0] stat_words,
  output logic [31:0] stat_frames,
  output logic [$clog2(DEPTH+1)-1:0] stat_max_occ
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL = CW'(DEPTH - AFULL_GAP);
  localparam logic [CW-1:0] C_AEMP  = CW'(AEMPTY_LVL);

  typedef enum logic {
    S_IDLE,
    S_IN_FRAME
  } frm_st_t;

  tlvp_if_bus_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  frm_st_t       r_st;
  frm_st_t       w_st_nxt;
  logic          w_frm_ev;
  logic          r_ovf;
  logic          r_unf;
  logic          r_frm;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_ovf_ev;
  logic w_unf_ev;
  tlvp_if_bus_t w_head;

  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.usr_ob_wr & ~w_full;
  assign w_rd_acc = bus.ob_rd & ~w_empty;
  assign w_ovf_ev = bus.usr_ob_wr & w_full;
  assign w_unf_ev = bus.ob_rd & w_empty;
  assign w_head   = r_mem[r_rd_ptr];

  assign bus.usr_ob_full  = w_full;
  assign bus.usr_ob_afull = (r_count >= C_AFULL);
  assign bus.ob_empty     = w_empty;
  assign bus.ob_aempty    = (r_count <= C_AEMP);
  assign bus.ob_tlv       = w_empty ? '0 : w_head;

  // Storage needs no reset: reads are masked by the reset count.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.usr_ob_tlv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st <= S_IDLE;
    else        r_st <= w_st_nxt;
  end

  // A stray sot inside a frame restarts the frame at that word.
  always_comb begin
    w_st_nxt = r_st;
    w_frm_ev = 1'b0;
    if (w_wr_acc) begin
      unique case (r_st)
        S_IDLE: begin
          if (bus.usr_ob_tlv.sot) begin
            w_st_nxt = bus.usr_ob_tlv.eot ? S_IDLE : S_IN_FRAME;
          end else begin
            w_frm_ev = 1'b1;
          end
        end
        S_IN_FRAME: begin
          if (bus.usr_ob_tlv.sot) w_frm_ev = 1'b1;
          if (bus.usr_ob_tlv.eot) w_st_nxt = S_IDLE;
        end
        default: w_st_nxt = S_IDLE;
      endcase
    end
  end

  // Error events beat a concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_frm <= 1'b0;
    end else begin
      if (w_ovf_ev)     r_ovf <= 1'b1;
      else if (err_clr) r_ovf <= 1'b0;
      if (w_unf_ev)     r_unf <= 1'b1;
      else if (err_clr) r_unf <= 1'b0;
      if (w_frm_ev)     r_frm <= 1'b1;
      else if (err_clr) r_frm <= 1'b0;
    end
  end

  assign ovf_err   = r_ovf;
  assign unf_err   = r_unf;
  assign frame_err = r_frm;

`ifdef CR_PREFIX_OB_STATS_EN
  logic [31:0]   r_words;
  logic [31:0]   r_frames;
  logic [CW-1:0] r_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words  <= '0;
      r_frames <= '0;
      r_max    <= '0;
    end else if (err_clr) begin
      r_words  <= '0;
      r_frames <= '0;
      r_max    <= '0;
    end else begin
      if (w_rd_acc && r_words != '1)
        r_words <= r_words + 32'd1;
      if (w_rd_acc && w_head.eot && r_frames != '1)
        r_frames <= r_frames + 32'd1;
      if (r_count > r_max)
        r_max <= r_count;
    end
  end

  assign stat_words   = r_words;
  assign stat_frames  = r_frames;
  assign stat_max_occ = r_max;
`else
  assign stat_words   = '0;
  assign stat_frames  = '0;
  assign stat_max_occ = '0;
`endif

endmodule

// File: tb/tb_cr_prefix_attach_ob_buf.sv
// Directed self-checking bench for cr_prefix_attach_ob_buf.
// Stats expectations follow whether CR_PREFIX_OB_STATS_EN is defined.
module tb_cr_prefix_attach_ob_buf;
  import cr_prefix_pkg::*;

`ifdef CR_PREFIX_OB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_clr = 1'b0;
  logic ovf_err, unf_err, frame_err;
  logic [31:0] stat_words, stat_frames;
  logic [3:0]  stat_max_occ;
  int errors = 0;
  int checks = 0;

  cr_prefix_attach_ob_buf_if bus();

  cr_prefix_attach_ob_buf dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .err_clr(err_clr),
    .ovf_err(ovf_err),
    .unf_err(unf_err),
    .frame_err(frame_err),
    .stat_words(stat_words),
    .stat_frames(stat_frames),
    .stat_max_occ(stat_max_occ)
  );

  always #5 clk = ~clk;

  function automatic tlvp_if_bus_t mk(bit s, bit e, int i);
    tlvp_if_bus_t t;
    t.sot = s;
    t.eot = e;
    t.typen = 4'(i + 1);
    t.tdata = 32'hA500_0000 + 32'(i);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.usr_ob_wr = 1'b0;
    bus.ob_rd = 1'b0;
    bus.usr_ob_tlv = '0;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic wr(input tlvp_if_bus_t t);
    bus.usr_ob_wr = 1'b1;
    bus.usr_ob_tlv = t;
    step();
    bus.usr_ob_wr = 1'b0;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.usr_ob_full, bus.usr_ob_afull,
         bus.ob_empty, bus.ob_aempty} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0011",
        {bus.usr_ob_full, bus.usr_ob_afull, bus.ob_empty, bus.ob_aempty});
    end
    checks++;
    if (bus.ob_tlv !== '0 || {ovf_err, unf_err, frame_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_out tlv=%h err=%b exp 0/000",
        bus.ob_tlv, {ovf_err, unf_err, frame_err});
    end
    checks++;
    if (stat_words !== 0 || stat_frames !== 0 || stat_max_occ !== 0) begin
      errors++;
      $display("FAIL reset_stats w=%0d f=%0d m=%0d exp 0",
        stat_words, stat_frames, stat_max_occ);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_three_words();
    tlvp_if_bus_t w [3];
    w[0] = mk(1, 0, 0);
    w[1] = mk(0, 0, 1);
    w[2] = mk(0, 1, 2);
    do_reset();
    wr(w[0]);
    checks++;
    if (bus.ob_empty !== 1'b0 || bus.ob_tlv !== w[0]) begin
      errors++;
      $display("FAIL first_word empty=%b tlv=%h exp 0/%h",
        bus.ob_empty, bus.ob_tlv, w[0]);
    end
    wr(w[1]);
    wr(w[2]);
    checks++;
    if ({bus.ob_aempty, bus.usr_ob_afull, frame_err} !== 3'b000
        || bus.ob_tlv !== w[0]) begin
      errors++;
      $display("FAIL three_words ae/af/fe=%b tlv=%h exp 000/%h",
        {bus.ob_aempty, bus.usr_ob_afull, frame_err}, bus.ob_tlv, w[0]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.ob_tlv !== w[i]) begin
        errors++;
        $display("FAIL three_pop%0d got=%h exp=%h", i, bus.ob_tlv, w[i]);
      end
      bus.ob_rd = 1'b1;
      step();
      bus.ob_rd = 1'b0;
    end
    checks++;
    if (bus.ob_empty !== 1'b1 || unf_err !== 1'b0) begin
      errors++;
      $display("FAIL three_empty empty=%b unf=%b exp 1/0",
        bus.ob_empty, unf_err);
    end
  endtask

  task automatic fill8();
    for (int i = 0; i < 8; i++) begin
      wr(mk(i == 0, i == 7, i));
      if (i == 4 || i == 5) begin
        checks++;
        if (bus.usr_ob_afull !== (i == 5)) begin
          errors++;
          $display("FAIL afull_w%0d got=%b exp=%b",
            i + 1, bus.usr_ob_afull, i == 5);
        end
      end
      if (i == 6 || i == 7) begin
        checks++;
        if (bus.usr_ob_full !== (i == 7)) begin
          errors++;
          $display("FAIL full_w%0d got=%b exp=%b",
            i + 1, bus.usr_ob_full, i == 7);
        end
      end
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    fill8();
    wr(mk(1, 1, 9));
    checks++;
    if (ovf_err !== 1'b1 || bus.usr_ob_full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_9th ovf=%b full=%b exp 1/1",
        ovf_err, bus.usr_ob_full);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.ob_tlv !== mk(i == 0, i == 7, i)) begin
        errors++;
        $display("FAIL drain%0d got=%h exp=%h",
          i, bus.ob_tlv, mk(i == 0, i == 7, i));
      end
      bus.ob_rd = 1'b1;
      step();
      bus.ob_rd = 1'b0;
    end
    checks++;
    if (bus.ob_empty !== 1'b1 || bus.ob_tlv !== '0) begin
      errors++;
      $display("FAIL drain_empty empty=%b tlv=%h exp 1/0",
        bus.ob_empty, bus.ob_tlv);
    end
  endtask

  task automatic test_full_wr_rd();
    do_reset();
    fill8();
    bus.usr_ob_wr = 1'b1;
    bus.usr_ob_tlv = mk(1, 1, 12);
    bus.ob_rd = 1'b1;
    step();
    idle_in();
    checks++;
    if ({ovf_err, bus.usr_ob_full, bus.usr_ob_afull} !== 3'b101) begin
      errors++;
      $display("FAIL full_wr_rd ovf/full/afull=%b exp 101",
        {ovf_err, bus.usr_ob_full, bus.usr_ob_afull});
    end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (bus.ob_tlv !== mk(i == 0, i == 7, i)) begin
        errors++;
        $display("FAIL wrrd_pop%0d got=%h exp=%h",
          i, bus.ob_tlv, mk(i == 0, i == 7, i));
      end
      bus.ob_rd = 1'b1;
      step();
      bus.ob_rd = 1'b0;
    end
    checks++;
    if (bus.ob_empty !== 1'b1) begin
      errors++;
      $display("FAIL wrrd_count7 empty=%b exp 1", bus.ob_empty);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    bus.ob_rd = 1'b1;
    step();
    bus.ob_rd = 1'b0;
    checks++;
    if (unf_err !== 1'b1 || bus.ob_empty !== 1'b1) begin
      errors++;
      $display("FAIL unf_set unf=%b empty=%b exp 1/1",
        unf_err, bus.ob_empty);
    end
    wr(mk(1, 1, 3));
    checks++;
    if (bus.ob_tlv !== mk(1, 1, 3) || bus.ob_aempty !== 1'b1) begin
      errors++;
      $display("FAIL unf_ptr tlv=%h ae=%b exp %h/1",
        bus.ob_tlv, bus.ob_aempty, mk(1, 1, 3));
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (unf_err !== 1'b0) begin
      errors++;
      $display("FAIL unf_clr got=%b exp=0", unf_err);
    end
    bus.ob_rd = 1'b1;
    step();
    err_clr = 1'b1;
    step();
    idle_in();
    checks++;
    if (unf_err !== 1'b1 || bus.ob_empty !== 1'b1) begin
      errors++;
      $display("FAIL unf_clr_race unf=%b empty=%b exp 1/1",
        unf_err, bus.ob_empty);
    end
  endtask

  task automatic test_frame();
    do_reset();
    wr(mk(1, 0, 0));
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frm_sot got=%b exp=0", frame_err);
    end
    wr(mk(1, 0, 1));
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frm_2nd_sot got=%b exp=1", frame_err);
    end
    wr(mk(0, 1, 2));
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    wr(mk(1, 1, 3));
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frm_single got=%b exp=0", frame_err);
    end
    wr(mk(0, 0, 4));
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL frm_nosot got=%b exp=1", frame_err);
    end
  endtask

  task automatic test_stats();
    tlvp_if_bus_t w [5];
    w[0] = mk(1, 0, 0);
    w[1] = mk(0, 1, 1);
    w[2] = mk(1, 1, 2);
    w[3] = mk(1, 0, 3);
    w[4] = mk(0, 0, 4);
    do_reset();
    for (int i = 0; i < 5; i++) wr(w[i]);
    step();
    for (int i = 0; i < 5; i++) begin
      bus.ob_rd = 1'b1;
      step();
    end
    bus.ob_rd = 1'b0;
    step();
    checks++;
    if (stat_words !== (STATS ? 32'd5 : 32'd0)
        || stat_frames !== (STATS ? 32'd2 : 32'd0)) begin
      errors++;
      $display("FAIL stats_cnt w=%0d f=%0d exp %0d/%0d",
        stat_words, stat_frames, STATS ? 5 : 0, STATS ? 2 : 0);
    end
    checks++;
    if (stat_max_occ !== (STATS ? 4'd5 : 4'd0)) begin
      errors++;
      $display("FAIL stats_max got=%0d exp=%0d",
        stat_max_occ, STATS ? 5 : 0);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (stat_words !== 0 || stat_frames !== 0 || stat_max_occ !== 0) begin
      errors++;
      $display("FAIL stats_clr w=%0d f=%0d m=%0d exp 0",
        stat_words, stat_frames, stat_max_occ);
    end
  endtask

  initial begin
    test_reset();
    test_three_words();
    test_fill_drain();
    test_full_wr_rd();
    test_underflow();
    test_frame();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
